// File: rtl/multicycle_seq.sv
// Multi-cycle RV32 sequencer: FETCH/DECODE/EXEC/MEM/WB control with memory
// req/ack handshakes, retired-instruction counter and sticky trap on illegal op or timeout.
module multicycle_seq #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [6:0]       op,
  input  logic             br_taken,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             ir_wr,
  output logic             reg_wr,
  output logic             pc_wr,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             busy,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_MEM    = 3'd4;
  localparam logic [2:0] S_WB     = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd7;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_J     = 7'b1101111;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]       r_state;
  logic [7:0]       r_tmo;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_retired;

  logic       w_is_alu, w_is_ld, w_is_st, w_is_b, w_is_j, w_legal;
  logic [2:0] w_nxt;
  logic [2:0] w_boundary;
  logic [1:0] w_cause;
  logic       w_pc_wr;
  logic [1:0] w_pc_sel;
  logic       w_tmo_last;

  always_comb begin
    w_is_alu = (op == OP_R) || (op == OP_I) || (op == OP_LUI);
    w_is_ld  = (op == OP_LOAD);
    w_is_st  = (op == OP_STORE);
    w_is_b   = (op == OP_B);
    w_is_j   = (op == OP_J);
    w_legal  = w_is_alu || w_is_ld || w_is_st || w_is_b || w_is_j;
  end

  assign w_tmo_last = (r_tmo == TMO_LAST);
  // Instruction boundary: run is only honoured where the next state would be FETCH
  assign w_boundary = run ? S_FETCH : S_IDLE;

  always_comb begin
    w_nxt    = r_state;
    w_cause  = r_cause;
    w_pc_wr  = 1'b0;
    w_pc_sel = 2'b00;
    case (r_state)
      S_IDLE:   if (run) w_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          w_nxt = S_DECODE;
        end else if (w_tmo_last) begin
          w_nxt   = S_TRAP;
          w_cause = 2'b10;
        end
      end
      S_DECODE: begin
        if (w_legal) begin
          w_nxt = S_EXEC;
        end else begin
          w_nxt   = S_TRAP;
          w_cause = 2'b01;
        end
      end
      S_EXEC: begin
        if (w_is_b) begin
          w_pc_wr  = 1'b1;
          w_pc_sel = br_taken ? 2'b01 : 2'b00;
          w_nxt    = w_boundary;
        end else if (w_is_j) begin
          w_pc_wr  = 1'b1;
          w_pc_sel = 2'b10;
          w_nxt    = w_boundary;
        end else if (w_is_ld || w_is_st) begin
          w_nxt = S_MEM;
        end else begin
          w_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (w_is_st) begin
            w_pc_wr = 1'b1;
            w_nxt   = w_boundary;
          end else begin
            w_nxt = S_WB;
          end
        end else if (w_tmo_last) begin
          w_nxt   = S_TRAP;
          w_cause = 2'b11;
        end
      end
      S_WB: begin
        w_pc_wr = 1'b1;
        w_nxt   = w_boundary;
      end
      default:  w_nxt = S_TRAP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_tmo     <= '0;
      r_cause   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_nxt;
      r_cause <= w_cause;
      // Any state change restarts the wait count; staying in FETCH/MEM means no ack
      if (w_nxt != r_state)
        r_tmo <= '0;
      else if ((r_state == S_FETCH) || (r_state == S_MEM))
        r_tmo <= r_tmo + 8'd1;
      if (w_pc_wr)
        r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign imem_req   = (r_state == S_FETCH);
  assign ir_wr      = imem_req && imem_ack;
  assign dmem_req   = (r_state == S_MEM);
  assign dmem_we    = dmem_req && w_is_st;
  assign reg_wr     = (r_state == S_WB);
  assign pc_wr      = w_pc_wr;
  assign pc_sel     = w_pc_sel;
  assign state      = r_state;
  assign busy       = (r_state != S_IDLE) && (r_state != S_TRAP);
  assign trap_cause = r_cause;
  assign retired    = r_retired;

endmodule
